// File: rtl/ahb_matrix_input_stage.sv
// ahb_matrix_input_stage: master-facing end of one bus-matrix port; holds unaccepted address phases and tracks the data phase
module ahb_matrix_input_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int MW         = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic [MW-1:0]         HMASTERS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  input  logic                  grant,
  input  logic                  hready_m,
  input  logic                  data_ready,
  input  logic                  data_resp,
  output logic                  active_trans,
  output logic                  sel_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]            htrans_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [3:0]            hprot_o,
  output logic [MW-1:0]         hmaster_o,
  output logic                  hmastlock_o
);
  localparam int FW = ADDR_WIDTH + 2 + 1 + 3 + 3 + 4 + MW + 1;
  logic          hold_q, hold_d, dp_q, dp_d, new_trans, accept;
  logic [FW-1:0] fields_in, fields_q, fields_d;
  assign fields_in = {HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS, HMASTLOCKS};
  assign new_trans = HSELS & HREADYS & HTRANSS[1];
  assign accept    = grant & hready_m;
  assign {haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hprot_o, hmaster_o, hmastlock_o} =
    hold_q ? fields_q : fields_in;
  assign sel_o        = hold_q | (HSELS & HREADYS);
  assign active_trans = hold_q | new_trans;
  assign HREADYOUTS   = dp_q ? data_ready : !hold_q;
  assign HRESPS       = dp_q & data_resp;
  // next state: capture a refused transfer, release it on accept, and track the data phase it launches
  always_comb begin
    hold_d   = hold_q ? !accept : new_trans & !accept;
    fields_d = (!hold_q & new_trans & !accept) ? fields_in : fields_q;
    dp_d     = (accept & (hold_q | new_trans)) | (dp_q & !data_ready);
  end
  // state registers; asynchronous reset drops any held transfer immediately
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_q   <= 1'b0;
      dp_q     <= 1'b0;
      fields_q <= '0;
    end else begin
      hold_q   <= hold_d;
      dp_q     <= dp_d;
      fields_q <= fields_d;
    end
  end
endmodule

// File: tb/tb_ahb_matrix_input_stage.sv
// tb_ahb_matrix_input_stage: directed and random checks against a transaction-level model of the input stage
module tb_ahb_matrix_input_stage;
  localparam int AW = 32;
  localparam int MW = 4;
  logic          HCLK = 1'b0, HRESETn = 1'b0;
  logic          HSELS = 1'b0, HWRITES = 1'b0, HMASTLOCKS = 1'b0, HREADYS = 1'b1;
  logic [AW-1:0] HADDRS = '0;
  logic [1:0]    HTRANSS = 2'b00;
  logic [2:0]    HSIZES = '0, HBURSTS = '0;
  logic [3:0]    HPROTS = '0;
  logic [MW-1:0] HMASTERS = '0;
  logic          grant = 1'b0, hready_m = 1'b0, data_ready = 1'b0, data_resp = 1'b0;
  logic          HREADYOUTS, HRESPS, active_trans, sel_o, hwrite_o, hmastlock_o;
  logic [AW-1:0] haddr_o;
  logic [1:0]    htrans_o;
  logic [2:0]    hsize_o, hburst_o;
  logic [3:0]    hprot_o;
  logic [MW-1:0] hmaster_o;

  ahb_matrix_input_stage #(.ADDR_WIDTH(AW), .MW(MW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .grant(grant), .hready_m(hready_m),
    .data_ready(data_ready), .data_resp(data_resp), .active_trans(active_trans),
    .sel_o(sel_o), .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o),
    .hsize_o(hsize_o), .hburst_o(hburst_o), .hprot_o(hprot_o), .hmaster_o(hmaster_o),
    .hmastlock_o(hmastlock_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [3:0]    prot;
    logic [MW-1:0] master;
    logic          lock;
  } xfer_t;

  xfer_t pend, cur, pres;
  bit    pend_v = 0, busy = 0, kill_rdy = 0;
  int    total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // one bus cycle: drive inputs, check outputs against the model, then advance the model
  task automatic cycle(input bit sel, input logic [1:0] tr, input logic [AW-1:0] a,
                       input bit g, input bit hm, input bit dr, input bit dres);
    bit exp_rdy, newt, offered, issued;
    @(negedge HCLK);
    HSELS = sel; HTRANSS = tr; HADDRS = a;
    HWRITES = 1'($urandom); HSIZES = 3'($urandom); HBURSTS = 3'($urandom);
    HPROTS = 4'($urandom); HMASTERS = MW'($urandom); HMASTLOCKS = 1'($urandom);
    grant = g; hready_m = hm; data_ready = dr; data_resp = dres;
    exp_rdy = busy ? dr : !pend_v;
    HREADYS = exp_rdy & !kill_rdy;
    #1;
    cur     = '{HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS, HMASTLOCKS};
    newt    = sel & HREADYS & tr[1];
    offered = pend_v | newt;
    pres    = pend_v ? pend : cur;
    chk("hreadyout", HREADYOUTS, exp_rdy);
    chk("hresp", HRESPS, busy ? dres : 1'b0);
    chk("active", active_trans, offered);
    chk("sel", sel_o, pend_v | (sel & HREADYS));
    chk("haddr", haddr_o, pres.addr);
    chk("htrans", htrans_o, pres.trans);
    chk("hwrite", hwrite_o, pres.write);
    chk("hsize", hsize_o, pres.size);
    chk("hburst", hburst_o, pres.burst);
    chk("hprot", hprot_o, pres.prot);
    chk("hmaster", hmaster_o, pres.master);
    chk("hlock", hmastlock_o, pres.lock);
    issued = offered & g & hm;
    busy   = issued | (busy & !dr);
    if (issued) pend_v = 0;
    else if (newt) begin pend_v = 1; pend = cur; end
  endtask

  initial begin
    #2;
    chk("rst_hreadyout", HREADYOUTS, 1'b1);
    chk("rst_hresp", HRESPS, 1'b0);
    chk("rst_active", active_trans, 1'b0);
    HREADYS = 1'b0;
    #1;
    chk("rst_sel", sel_o, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    // zero-latency accept, then data phase following data_ready
    cycle(1, 2'b10, 32'h1000, 1, 1, 1, 0);
    chk("dp_wait", (busy == 1), 1'b1);
    cycle(0, 2'b00, 0, 1, 1, 0, 0);
    cycle(0, 2'b00, 0, 1, 1, 1, 0);
    // refused NONSEQ held for three cycles, then granted
    cycle(1, 2'b10, 32'h2000, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 2'b10, 32'h9999, 0, 1, 1, 0);
    cycle(0, 2'b00, 0, 1, 1, 1, 0);
    cycle(0, 2'b00, 0, 1, 1, 1, 0);
    // INCR4 with one wait state on beat 2
    cycle(1, 2'b10, 32'h3000, 1, 1, 1, 0);
    cycle(1, 2'b11, 32'h3004, 1, 1, 1, 0);
    cycle(1, 2'b11, 32'h3008, 1, 1, 0, 0);
    cycle(1, 2'b11, 32'h3008, 1, 1, 1, 0);
    cycle(1, 2'b11, 32'h300c, 1, 1, 1, 0);
    // BUSY mid-burst, then ERROR two-cycle response followed by IDLE
    cycle(1, 2'b01, 32'h3010, 1, 1, 1, 0);
    cycle(1, 2'b10, 32'h4000, 1, 1, 1, 0);
    cycle(0, 2'b00, 0, 1, 1, 0, 1);
    cycle(1, 2'b00, 32'h4004, 1, 1, 1, 1);
    cycle(0, 2'b00, 0, 1, 1, 1, 0);
    // asynchronous reset while a transfer is held
    cycle(1, 2'b10, 32'h5000, 0, 1, 1, 0);
    cycle(0, 2'b00, 0, 0, 1, 1, 0);
    @(negedge HCLK);
    HSELS = 0; HTRANSS = 2'b00; HREADYS = 0;
    #2;
    HRESETn = 1'b0;
    #1;
    pend_v = 0; busy = 0;
    chk("arst_hreadyout", HREADYOUTS, 1'b1);
    chk("arst_active", active_trans, 1'b0);
    chk("arst_sel", sel_o, 1'b0);
    chk("arst_hresp", HRESPS, 1'b0);
    HRESETn = 1'b1;
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      kill_rdy = ($urandom_range(0, 9) == 0);
      cycle(1'($urandom), 2'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_matrix_input_stage.md
Name: ahb_matrix_input_stage

Overview:
- Bus-matrix input stage: the master-facing end of one matrix port. Drives the request that the per-slave output arbiters consume.
- Captures each master address phase. Holds it in a register when the target output port does not accept it in the same cycle, and stalls the master until it is accepted.
- Tracks this port's data phase and returns the slave's HREADY/HRESP to the master.
- One instance per master port, between the master and the address decoder / output stages.

Parameters:
- ADDR_WIDTH, 32, width of HADDRS / held address
- MW, 4, width of HMASTERS / held master ID

Ports:
- HCLK  input  1  AHB system clock
- HRESETn  input  1  asynchronous active-low reset
- HSELS  input  1  port select from master side
- HADDRS  input  ADDR_WIDTH  address
- HTRANSS  input  2  transfer type
- HWRITES  input  1  write
- HSIZES  input  3  size
- HBURSTS  input  3  burst
- HPROTS  input  4  protection
- HMASTERS  input  MW  master ID
- HMASTLOCKS  input  1  locked
- HREADYS  input  1  bus HREADY seen by master
- HREADYOUTS  output  1  ready to master
- HRESPS  output  1  response to master (0 OKAY, 1 ERROR)
- grant  input  1  addressed output stage currently selects this port (addr_in_port match and !no_port)
- hready_m  input  1  HREADY of addressed output port
- data_ready  input  1  HREADYOUT of slave in this port's data phase
- data_resp  input  1  HRESP of that slave
- active_trans  output  1  request to output arbiters (req_portN)
- sel_o  output  1  valid address phase presented downstream
- haddr_o / htrans_o / hwrite_o / hsize_o / hburst_o / hprot_o / hmaster_o / hmastlock_o  output  as inputs  address phase presented downstream

Behaviour:
- new_trans = HSELS & HREADYS & HTRANSS[1] (NONSEQ or SEQ).
- accept = grant & hready_m.
- Hold register (hold_valid plus copies of all address-phase fields):
  - Loads the inputs when new_trans & !accept.
  - Clears when hold_valid & accept.
  - Otherwise holds its value.
  - Never loads while hold_valid=1: the master is stalled, so no new_trans can occur.
- Downstream mux: hold_valid=1 presents the held fields with sel_o=1. Otherwise it passes HADDRS… through, with sel_o = HSELS & HREADYS.
- active_trans = hold_valid | new_trans (combinational, zero latency).
- data_phase register:
  - Set on accept of a NONSEQ/SEQ.
  - Cleared when data_ready=1 and no new accept in the same cycle.
  - Back-to-back: accept in the completing cycle keeps it at 1.
- HREADYOUTS:
  - data_phase=1: data_ready.
  - Else hold_valid=1: 0.
  - Else 1.
- HRESPS = data_phase ? data_resp : 0.
- ERROR two-cycle response: the first cycle (data_resp=1, data_ready=0) is passed through unchanged.
  - If the master drives IDLE on the second cycle, the stage captures nothing.
  - A transfer already held stays held and is issued.
- BUSY and IDLE are never captured and never raise active_trans.
  - Exception: while hold_valid=1, a held SEQ is presented unchanged.
- Locked sequences: hmastlock_o follows the held or passed value. Lock arbitration is the output stage's job.
- Simultaneous events:
  - hold clear and new_trans in the same cycle cannot occur, because HREADYOUTS=0 whenever hold_valid=1.
  - accept and data_ready in the same cycle: next transfer enters data phase, previous completes.
- Reset values:
  - hold_valid=0, data_phase=0, held fields all 0.
  - HREADYOUTS=1, HRESPS=0, active_trans=0, sel_o=0 (with inputs idle).
- Reset asserted mid-hold discards the held transfer immediately (asynchronous).
- Latency:
  - Accepted in the cycle it arrives when grant & hready_m, i.e. zero added cycles.
  - Otherwise held until grant. The master sees HREADYOUTS=0 for each wait cycle.

Test Plan:
- Idle port, NONSEQ addr 0x1000 with grant=1, hready_m=1 -> no hold. haddr_o=0x1000 same cycle, active_trans=1. Next cycle data_phase=1 and HREADYOUTS follows data_ready.
- NONSEQ addr 0x2000 with grant=0 for 3 cycles, then grant=1 -> hold_valid=1 for 3 cycles. haddr_o=0x2000 held, HREADYOUTS=0 for the 3 cycles, active_trans=1 throughout. Hold clears on grant, then the data phase starts.
- INCR4 burst, slave inserts 1 wait state on beat 2 -> HREADYOUTS low exactly that cycle. All 4 beats are accepted back-to-back and data_phase stays 1 across them.
- Data phase ERROR, data_resp=1 for 2 cycles with data_ready 0 then 1, master then IDLE -> HRESPS=1 both cycles, HREADYOUTS 0 then 1. No capture of the IDLE, active_trans=0.
- BUSY inside burst, HTRANSS=01 -> active_trans=0, no capture, HREADYOUTS=1.
- HRESETn asserted while hold_valid=1 -> hold_valid, data_phase, active_trans go to 0 and HREADYOUTS to 1 without a clock edge.
